// File: rtl/modulation_segment_mapper_if.sv
// Bit-in / sample-out handshake bundle for the BPSK segment mapper.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface modulation_segment_mapper_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/modulation_segment_mapper.sv
// BPSK segment mapper: each accepted bit becomes SEG_LEN samples from a programmable
// reference table, passed through or saturating-negated depending on the bit.
module modulation_segment_mapper #(
    parameter int DATA_W  = 32,
    parameter int SEG_LEN = 8,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic                space_bit,
    modulation_segment_mapper_if.slave bus,
    output logic                busy,
    output logic [CNT_W-1:0]    seg_count,
    output logic                dbg_state_o,
    output logic [ADDR_W-1:0]   dbg_idx_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(SEG_LEN - 1);
    localparam logic [ADDR_W:0]   SEG_LEN_EXT = (ADDR_W + 1)'(SEG_LEN);
    localparam logic [DATA_W-1:0] MIN_VAL     = {1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_VAL     = {1'b0, {(DATA_W - 1){1'b1}}};

    state_e            state_q, state_d;
    logic              sym_q, sym_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [CNT_W-1:0]  seg_count_q, seg_count_d;
    logic [DATA_W-1:0] ref_mem_q [SEG_LEN];

    logic              out_valid;
    logic              hs;
    logic              in_ready;
    logic              accept;
    logic              ref_we;
    logic [ADDR_W-1:0] idx_inc;

    // The most negative value has no positive twin, so it maps to the largest positive one.
    function automatic logic [DATA_W-1:0] map_sample(
        input logic [DATA_W-1:0] x,
        input logic              b,
        input logic              sp
    );
        if (b == sp) begin
            return x;
        end
        if (x == MIN_VAL) begin
            return MAX_VAL;
        end
        return -x;
    endfunction

    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        seg_count_d = seg_count_q;

        out_valid = (state_q == RUN);
        hs        = out_valid & bus.out_ready;
        // Combinational from out_ready so a new bit can follow the last sample without a bubble.
        in_ready  = (state_q == IDLE) | (hs & out_last_q);
        accept    = bus.in_valid & in_ready;
        ref_we    = cfg_we & (state_q == IDLE) & ({1'b0, cfg_addr} < SEG_LEN_EXT);
        idx_inc   = idx_q + ADDR_W'(1);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (!out_last_q) begin
                        idx_d      = idx_inc;
                        out_data_d = map_sample(ref_mem_q[idx_inc], sym_q, space_bit);
                        out_last_d = (idx_inc == LAST_IDX);
                    end else begin
                        seg_count_d = seg_count_q + CNT_W'(1);
                        if (!bus.in_valid) begin
                            state_d    = IDLE;
                            out_last_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new segment always starts from table entry 0 with the freshly captured bit.
        if (accept) begin
            sym_d      = bus.in_bit;
            idx_d      = '0;
            out_data_d = map_sample(ref_mem_q[0], bus.in_bit, space_bit);
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sym_q       <= 1'b0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            seg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            seg_count_q <= seg_count_d;
        end
    end

    // Table writes only land while idle, so a running segment never sees a mixed table.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEG_LEN; i++) begin
                ref_mem_q[i] <= '0;
            end
        end else if (ref_we) begin
            ref_mem_q[cfg_addr] <= cfg_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == RUN);
    assign seg_count     = seg_count_q;
    assign dbg_state_o   = state_q;
    assign dbg_idx_o     = idx_q;

endmodule
